vga_sync_rx: RTL and testbench



---
 rtl/vga_sync_if.sv | 27 ++
 rtl/vga_sync_rx.sv | 168 ++++++++++++++++
 tb/tb_vga_sync_rx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Sync-stream bundle between a VGA timing source and vga_sync_rx.
// The master drives the sync inputs; the slave returns coordinates and lock status.
interface vga_sync_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_valid;
  logic       frame_start;
  logic       locked;
  logic       sync_err;
  logic [9:0] meas_h_total;
  logic [9:0] meas_v_total;

  modport master (
    output hsync, vsync, video_on,
    input  pix_x, pix_y, pix_valid, frame_start, locked, sync_err,
           meas_h_total, meas_v_total
  );

  modport slave (
    input  hsync, vsync, video_on,
    output pix_x, pix_y, pix_valid, frame_start, locked, sync_err,
           meas_h_total, meas_v_total
  );
endinterface

// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing decoder: rebuilds pixel coordinates, measures line and
// frame geometry, and runs a lock FSM that verifies whole frames against nominal timing.
module vga_sync_rx #(
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  vga_sync_if.slave  bus
);

  localparam logic [9:0] HT = 10'(H_TOTAL);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] VA = 10'(V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic       hs_d, vs_d, von_d;
  logic       hs_fall, vs_fall, von_rise, von_fall;
  logic [9:0] pix_x, pix_y;
  logic       pix_valid, frame_start, new_frame;
  logic [9:0] hp_cnt, line_cnt, act_cnt, vact_cnt;
  logic [9:0] meas_h_total, meas_v_total;
  logic [9:0] lines_now, vact_now;
  logic       h_seen;
  logic       mismatch;
  state_t     state;
  logic       bad, locked, sync_err;

  always_comb begin
    hs_fall   = hs_d & ~bus.hsync;
    vs_fall   = vs_d & ~bus.vsync;
    von_rise  = bus.video_on & ~von_d;
    von_fall  = ~bus.video_on & von_d;
    // An edge coinciding with vs_fall belongs to the frame that is ending.
    lines_now = hs_fall  ? sat_inc(line_cnt) : line_cnt;
    vact_now  = von_rise ? sat_inc(vact_cnt) : vact_cnt;
    mismatch  = (hs_fall & h_seen & (hp_cnt != HT))
              | (von_fall & (act_cnt != HA))
              | (vs_fall & ((lines_now != VT) | (vact_now != VA)));
  end

  // NOTE: reset is sampled on the clock edge and all state uses non-blocking
  // assignments, so every block sees the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      von_d       <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      new_frame   <= 1'b0;
    end else begin
      hs_d        <= bus.hsync;
      vs_d        <= bus.vsync;
      von_d       <= bus.video_on;
      pix_valid   <= bus.video_on;
      frame_start <= von_rise & new_frame;
      if (von_rise) begin
        pix_x <= '0;
        if (new_frame) begin
          pix_y     <= '0;
          new_frame <= 1'b0;
        end else begin
          pix_y <= pix_y + 10'd1;
        end
      end else if (bus.video_on) begin
        pix_x <= pix_x + 10'd1;
      end
      if (vs_fall) new_frame <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hp_cnt       <= '0;
      line_cnt     <= '0;
      act_cnt      <= '0;
      vact_cnt     <= '0;
      h_seen       <= 1'b0;
      meas_h_total <= '0;
      meas_v_total <= '0;
    end else begin
      if (hs_fall) begin
        hp_cnt       <= 10'd1;
        meas_h_total <= hp_cnt;
        h_seen       <= 1'b1;
      end else begin
        hp_cnt <= sat_inc(hp_cnt);
      end

      if (vs_fall) begin
        meas_v_total <= lines_now;
        line_cnt     <= '0;
        vact_cnt     <= '0;
      end else begin
        line_cnt <= lines_now;
        vact_cnt <= vact_now;
      end

      if (von_rise)          act_cnt <= 10'd1;
      else if (bus.video_on) act_cnt <= sat_inc(act_cnt);
    end
  end

  // A frame is judged at the vs_fall that closes it, including checks made on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEARCH;
      bad      <= 1'b0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        SEARCH: begin
          locked <= 1'b0;
          if (vs_fall) begin
            state <= CHECK;
            bad   <= 1'b0;
          end
        end
        CHECK: begin
          if (vs_fall) begin
            if (bad || mismatch) begin
              bad <= 1'b0;
            end else begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else if (mismatch) begin
            bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            sync_err <= 1'b1;
            locked   <= 1'b0;
            state    <= SEARCH;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pix_x        = pix_x;
  assign bus.pix_y        = pix_y;
  assign bus.pix_valid    = pix_valid;
  assign bus.frame_start  = frame_start;
  assign bus.locked       = locked;
  assign bus.sync_err     = sync_err;
  assign bus.meas_h_total = meas_h_total;
  assign bus.meas_v_total = meas_v_total;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Self-checking bench for vga_sync_rx on a shrunken 20x10 timing (12x6 active)
// so that several whole frames fit in a short run.
module tb_vga_sync_rx;

  localparam int HT = 20;
  localparam int VT = 10;
  localparam int HA = 12;
  localparam int VA = 6;

  logic clk;
  logic rst_n;
  vga_sync_if bus ();

  vga_sync_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int fs_cnt   = 0;
  int se_cnt   = 0;

  always @(negedge clk) begin
    if (bus.frame_start) fs_cnt++;
    if (bus.sync_err)    se_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic h, input logic v, input logic von);
    bus.hsync    = h;
    bus.vsync    = v;
    bus.video_on = von;
    @(posedge clk);
    #1;
  endtask

  // One line of the generator: hsync low at h 14..15, vsync low on lines 7..8.
  task automatic drive_line(input int v, input int act, input int h_from, input int h_to);
    for (int h = h_from; h < h_to; h++)
      tick(!(h >= 14 && h < 16), !(v == 7 || v == 8), (v < VA) && (h < act));
  endtask

  task automatic drive_lines(input int v_from, input int v_to, input int skip_v);
    for (int v = v_from; v < v_to; v++)
      if (v != skip_v) drive_line(v, HA, 0, HT);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.hsync = 1'b1;
    bus.vsync = 1'b1;
    bus.video_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.pix_x, bus.pix_y, bus.pix_valid, bus.frame_start, bus.locked,
            bus.sync_err, bus.meas_h_total, bus.meas_v_total};
  endfunction

  typedef struct {
    logic       h, v, von;
    logic       pv;
    logic [9:0] px, py;
    logic       fs;
    logic [9:0] mh, mv;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int row_err;
    int pv_cnt;

    // Cycle-exact coordinate/measurement vectors straight out of reset.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 10'd0, 10'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd1, 10'd0, 1'b0, 10'd0, 10'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd2, 10'd0, 1'b0, 10'd0, 10'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd2, 10'd0, 1'b0, 10'd0, 10'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd1, 1'b0, 10'd0, 10'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd1, 10'd1, 1'b0, 10'd0, 10'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd1, 10'd1, 1'b0, 10'd8, 10'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd2, 1'b0, 10'd8, 10'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 10'd2, 1'b0, 10'd8, 10'd1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 10'd8, 10'd1};

    reset_dut();
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].h, vecs[i].v, vecs[i].von);
      check($sformatf("vec%0d", i),
            {bus.pix_valid, bus.pix_x, bus.pix_y, bus.frame_start, bus.meas_h_total, bus.meas_v_total},
            {vecs[i].pv, vecs[i].px, vecs[i].py, vecs[i].fs, vecs[i].mh, vecs[i].mv});
    end

    // Clean stream from reset: lock at the second vs_fall.
    reset_dut();
    check("reset_outs", all_outs(), 64'd0);
    se_cnt = 0;
    drive_lines(0, VT, -1);
    check("frame0_unlocked", bus.locked, 1'b0);
    fs_cnt = 0;
    drive_lines(0, 7, -1);
    check("pre_lock", bus.locked, 1'b0);
    drive_line(7, HA, 0, 1);
    check("lock_rise", bus.locked, 1'b1);
    drive_line(7, HA, 1, HT);
    drive_lines(8, VT, -1);
    check("fs_frame1", fs_cnt, 1);
    check("meas_h", bus.meas_h_total, 10'(HT));
    check("meas_v", bus.meas_v_total, 10'(VT));

    // Locked frame: one active row cycle by cycle, then pix_y progression.
    fs_cnt = 0;
    drive_lines(0, 3, -1);
    row_err = 0;
    pv_cnt  = 0;
    for (int h = 0; h < HT; h++) begin
      drive_line(3, HA, h, h + 1);
      if (bus.pix_valid) pv_cnt++;
      if (h < HA) begin
        if (!(bus.pix_valid && bus.pix_x == 10'(h) && bus.pix_y == 10'd3)) row_err++;
      end else begin
        if (!(!bus.pix_valid && bus.pix_x == 10'(HA - 1) && bus.pix_y == 10'd3)) row_err++;
      end
    end
    check("row3_coords", row_err, 0);
    check("row3_valid_cnt", pv_cnt, HA);
    drive_lines(4, 6, -1);
    check("last_row_y", bus.pix_y, 10'(VA - 1));
    drive_lines(6, VT, -1);
    check("fs_frame2", fs_cnt, 1);
    check("still_locked", bus.locked, 1'b1);

    // Next frame starts at (0,0); then line 4 stretched to 21 clocks.
    drive_line(0, HA, 0, 1);
    check("frame_start_y0", {bus.frame_start, bus.pix_y, bus.pix_x}, {1'b1, 10'd0, 10'd0});
    drive_line(0, HA, 1, HT);
    drive_lines(1, 4, -1);
    drive_line(4, HA, 0, HT + 1);
    drive_line(5, HA, 0, 14);
    check("pre_stretch_err", bus.sync_err, 1'b0);
    drive_line(5, HA, 14, 15);
    check("stretch_err", {bus.sync_err, bus.locked, bus.meas_h_total}, {1'b1, 1'b0, 10'(HT + 1)});
    drive_line(5, HA, 15, 16);
    check("stretch_pulse_1cy", bus.sync_err, 1'b0);
    drive_line(5, HA, 16, HT);
    drive_lines(6, VT, -1);
    check("stretch_search", bus.locked, 1'b0);
    drive_lines(0, 7, -1);
    check("relock_wait", bus.locked, 1'b0);
    drive_line(7, HA, 0, 1);
    check("relock", bus.locked, 1'b1);
    drive_line(7, HA, 1, HT);
    drive_lines(8, VT, -1);

    // Locked, one short active line (11 clocks).
    drive_lines(0, 2, -1);
    drive_line(2, HA - 1, 0, HA - 1);
    check("pre_drop_err", bus.sync_err, 1'b0);
    drive_line(2, HA - 1, HA - 1, HA);
    check("drop_err", {bus.sync_err, bus.locked}, {1'b1, 1'b0});
    drive_line(2, HA - 1, HA, HT);
    // CHECK is entered at line 7; line 9 is then skipped, giving a 9-line frame.
    drive_lines(3, VT, 9);
    drive_lines(0, 7, -1);
    drive_line(7, HA, 0, 1);
    check("short_frame_meas_v", bus.meas_v_total, 10'(VT - 1));
    check("short_frame_unlocked", bus.locked, 1'b0);
    drive_line(7, HA, 1, HT);
    drive_lines(8, VT, -1);
    check("sync_err_total", se_cnt, 2);
    drive_lines(0, 7, -1);
    drive_line(7, HA, 0, 1);
    check("lock_after_short", bus.locked, 1'b1);
    drive_line(7, HA, 1, HT);
    drive_lines(8, VT, -1);

    // One-cycle reset mid-frame while locked.
    drive_lines(0, 3, -1);
    drive_line(3, HA, 0, 5);
    rst_n = 1'b0;
    drive_line(3, HA, 5, 6);
    check("midframe_reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    drive_line(3, HA, 6, HT);
    drive_lines(4, VT, -1);
    check("post_reset_unlocked", bus.locked, 1'b0);
    drive_lines(0, 7, -1);
    check("post_reset_check", bus.locked, 1'b0);
    drive_line(7, HA, 0, 1);
    check("post_reset_lock", bus.locked, 1'b1);
    drive_line(7, HA, 1, HT);
    check("no_extra_sync_err", se_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
